event_buffer_tracker: RTL and testbench

Tracks the ring of fixed 512 KiB event buffers in DDR. It hands buffer addresses to the event writer and turns write completions into the 24-bit header completion stream consumed by the readout generator. It returns a buffer to the pool when the host acknowledges it. It sits directly upstream of the readout generator's `s_hdr_` port, entirely in the memclk domain.

---
 rtl/event_pkg.sv | 20 ++
 rtl/evbuf_hdr_reg.sv | 34 +++
 rtl/event_buffer_tracker.sv | 111 +++++++++++
 tb/tb_event_buffer_tracker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared definitions for the event-buffer tracker: buffer geometry,
// header field layout and the buffer upper-address helper.
package event_pkg;

    localparam int EVBUF_SIZE_LOG2 = 19;

    localparam int ERR_LSB   = 0;
    localparam int ADDR_LSB  = 8;
    localparam int ADDR_BITS = 13;
    localparam int HDR_BITS  = 24;

    // Upper address (addr[31:19]) of the buffer at ring slot 'index'.
    function automatic logic [ADDR_BITS-1:0] upper_addr(
        input logic [ADDR_BITS-1:0] base,
        input logic [ADDR_BITS-1:0] index
    );
        return base + index;
    endfunction

endpackage

// File: rtl/evbuf_hdr_reg.sv
// One-entry AXI4-Stream register stage for the header completion stream.
// Accepts a new word in the same cycle the held word drains, so headers
// can go out back to back.
module evbuf_hdr_reg
    import event_pkg::*;
#(
    parameter int W = HDR_BITS
) (
    input  logic         memclk,
    input  logic         aresetn,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    assign s_tready = !m_tvalid || m_tready;

    // Load on accept; data only changes when a new word is taken.
    always_ff @(posedge memclk) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/event_buffer_tracker.sv
// Event buffer ring tracker: hands out DDR buffer upper addresses, turns
// write completions into 24-bit headers and frees buffers on host ack.
// Optional build macro: EVBUF_ACK_CHECK_EN -- when defined, an ack must
// name the oldest completed buffer or it is dropped and flagged.
module event_buffer_tracker
    import event_pkg::*;
#(
    parameter int          NBUF       = 32,
    parameter logic [12:0] BASE_UPPER = 13'h0000
) (
    input  logic                  memclk,
    input  logic                  aresetn,
    output logic [12:0]           m_alloc_tdata,
    output logic                  m_alloc_tvalid,
    input  logic                  m_alloc_tready,
    input  logic [7:0]            s_wrdone_tdata,
    input  logic                  s_wrdone_tvalid,
    output logic                  s_wrdone_tready,
    output logic [23:0]           m_hdr_tdata,
    output logic                  m_hdr_tvalid,
    input  logic                  m_hdr_tready,
    input  logic [11:0]           s_ack_tdata,
    input  logic                  s_ack_tvalid,
    output logic                  s_ack_tready,
    output logic [$clog2(NBUF):0] occupancy_o,
    output logic                  ack_err_o
);

    localparam int IW = $clog2(NBUF);
    localparam int PW = IW + 1;

    logic [PW-1:0]        alloc_ptr, done_ptr, free_ptr;
    logic [PW-1:0]        alloc_nxt, done_nxt, free_nxt;
    logic [PW-1:0]        used;
    logic                 alloc_hs, wrdone_pending, wrdone_hs, hdr_in_ready;
    logic                 ack_ok;
    logic [ADDR_BITS-1:0] done_addr;
    logic [HDR_BITS-1:0]  hdr_data;

    assign used           = alloc_ptr - free_ptr;
    assign m_alloc_tvalid = used < PW'(NBUF);
    assign m_alloc_tdata  = upper_addr(BASE_UPPER, ADDR_BITS'(alloc_ptr[IW-1:0]));
    assign alloc_hs       = m_alloc_tvalid && m_alloc_tready;

    assign wrdone_pending  = done_ptr != alloc_ptr;
    assign s_wrdone_tready = wrdone_pending && hdr_in_ready;
    assign wrdone_hs       = s_wrdone_tvalid && s_wrdone_tready;
    assign done_addr       = upper_addr(BASE_UPPER, ADDR_BITS'(done_ptr[IW-1:0]));

    // Assemble the header word from its field offsets; spare MSBs stay 0.
    always_comb begin
        hdr_data                        = '0;
        hdr_data[ERR_LSB +: 8]          = s_wrdone_tdata;
        hdr_data[ADDR_LSB +: ADDR_BITS] = done_addr;
    end

    assign s_ack_tready = 1'b1;

`ifdef EVBUF_ACK_CHECK_EN
    logic [11:0] free_addr_lo;
    assign free_addr_lo = 12'(upper_addr(BASE_UPPER, ADDR_BITS'(free_ptr[IW-1:0])));
    assign ack_ok       = (free_ptr != done_ptr) && (s_ack_tdata == free_addr_lo);
`else
    logic unused_ack_data;
    assign unused_ack_data = ^s_ack_tdata;
    assign ack_ok          = free_ptr != done_ptr;
`endif

    // Next pointer values; each advances on its own handshake.
    always_comb begin
        alloc_nxt = alloc_ptr;
        done_nxt  = done_ptr;
        free_nxt  = free_ptr;
        if (alloc_hs) alloc_nxt = alloc_ptr + PW'(1);
        if (wrdone_hs) done_nxt = done_ptr + PW'(1);
        if (s_ack_tvalid && ack_ok) free_nxt = free_ptr + PW'(1);
    end

    // Pointer, occupancy and sticky ack-error registers.
    always_ff @(posedge memclk) begin
        if (!aresetn) begin
            alloc_ptr   <= '0;
            done_ptr    <= '0;
            free_ptr    <= '0;
            occupancy_o <= '0;
            ack_err_o   <= 1'b0;
        end else begin
            alloc_ptr   <= alloc_nxt;
            done_ptr    <= done_nxt;
            free_ptr    <= free_nxt;
            occupancy_o <= alloc_nxt - free_nxt;
            if (s_ack_tvalid && !ack_ok) begin
                ack_err_o <= 1'b1;
            end
        end
    end

    evbuf_hdr_reg #(
        .W (HDR_BITS)
    ) u_hdr_reg (
        .memclk   (memclk),
        .aresetn  (aresetn),
        .s_tdata  (hdr_data),
        .s_tvalid (s_wrdone_tvalid && wrdone_pending),
        .s_tready (hdr_in_ready),
        .m_tdata  (m_hdr_tdata),
        .m_tvalid (m_hdr_tvalid),
        .m_tready (m_hdr_tready)
    );

endmodule

// File: tb/tb_event_buffer_tracker.sv
// Randomized bench for event_buffer_tracker against a queue-based model
// of the buffer pool: buffers move allocated -> completed -> freed.
module tb_event_buffer_tracker;

    localparam int          NBUF       = 32;
    localparam logic [12:0] BASE_UPPER = 13'h0000;

    logic        memclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [12:0] m_alloc_tdata;
    logic        m_alloc_tvalid;
    logic        m_alloc_tready = 1'b0;
    logic [7:0]  s_wrdone_tdata = '0;
    logic        s_wrdone_tvalid = 1'b0;
    logic        s_wrdone_tready;
    logic [23:0] m_hdr_tdata;
    logic        m_hdr_tvalid;
    logic        m_hdr_tready = 1'b0;
    logic [11:0] s_ack_tdata = '0;
    logic        s_ack_tvalid = 1'b0;
    logic        s_ack_tready;
    logic [5:0]  occupancy_o;
    logic        ack_err_o;

    always #5 memclk = ~memclk;

    event_buffer_tracker #(
        .NBUF       (NBUF),
        .BASE_UPPER (BASE_UPPER)
    ) dut (
        .memclk          (memclk),
        .aresetn         (aresetn),
        .m_alloc_tdata   (m_alloc_tdata),
        .m_alloc_tvalid  (m_alloc_tvalid),
        .m_alloc_tready  (m_alloc_tready),
        .s_wrdone_tdata  (s_wrdone_tdata),
        .s_wrdone_tvalid (s_wrdone_tvalid),
        .s_wrdone_tready (s_wrdone_tready),
        .m_hdr_tdata     (m_hdr_tdata),
        .m_hdr_tvalid    (m_hdr_tvalid),
        .m_hdr_tready    (m_hdr_tready),
        .s_ack_tdata     (s_ack_tdata),
        .s_ack_tvalid    (s_ack_tvalid),
        .s_ack_tready    (s_ack_tready),
        .occupancy_o     (occupancy_o),
        .ack_err_o       (ack_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference pool state
    logic [12:0] alloc_q[$];
    logic [12:0] done_q[$];
    logic [23:0] hdr_q[$];
    int          alloc_cnt;
    logic        err_m;
    logic        saw_full = 1'b0;
    logic        saw_bp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge memclk);
        aresetn         = 1'b0;
        m_alloc_tready  = 1'b0;
        s_wrdone_tvalid = 1'b0;
        s_ack_tvalid    = 1'b0;
        m_hdr_tready    = 1'b0;
        repeat (4) @(posedge memclk);
        @(negedge memclk);
        chk("rst_alloc_tvalid", m_alloc_tvalid, 1);
        chk("rst_alloc_tdata", m_alloc_tdata, BASE_UPPER);
        chk("rst_hdr_tvalid", m_hdr_tvalid, 0);
        chk("rst_hdr_tdata", m_hdr_tdata, 0);
        chk("rst_wrdone_tready", s_wrdone_tready, 0);
        chk("rst_ack_tready", s_ack_tready, 1);
        chk("rst_occupancy", occupancy_o, 0);
        chk("rst_ack_err", ack_err_o, 0);
        alloc_q.delete();
        done_q.delete();
        hdr_q.delete();
        alloc_cnt = 0;
        err_m     = 1'b0;
        aresetn   = 1'b1;
    endtask

    task automatic run_cycle(input int p_alloc, input int p_wr, input int p_hdr,
                             input int p_ack, input int p_bad);
        logic        e_alloc_v, e_wr_r, e_hdr_v, ack_good;
        logic        a_hs, w_hs, h_hs;
        logic [12:0] a_addr, w_addr;
        int          occ;
        @(negedge memclk);
        m_alloc_tready  = $urandom_range(99) < p_alloc;
        s_wrdone_tvalid = $urandom_range(99) < p_wr;
        s_wrdone_tdata  = 8'($urandom);
        m_hdr_tready    = $urandom_range(99) < p_hdr;
        s_ack_tvalid    = $urandom_range(99) < p_ack;
        if (done_q.size() != 0 && $urandom_range(99) >= p_bad)
            s_ack_tdata = 12'(done_q[0]);
        else
            s_ack_tdata = 12'($urandom);
        #1;
        occ       = alloc_q.size() + done_q.size();
        e_alloc_v = occ < NBUF;
        e_hdr_v   = hdr_q.size() != 0;
        e_wr_r    = (alloc_q.size() != 0) && (!e_hdr_v || m_hdr_tready);
        a_addr    = BASE_UPPER + 13'(alloc_cnt % NBUF);
        chk("alloc_tvalid", m_alloc_tvalid, e_alloc_v);
        if (e_alloc_v) chk("alloc_tdata", m_alloc_tdata, a_addr);
        chk("occupancy", occupancy_o, occ);
        chk("wrdone_tready", s_wrdone_tready, e_wr_r);
        chk("hdr_tvalid", m_hdr_tvalid, e_hdr_v);
        if (e_hdr_v) chk("hdr_tdata", m_hdr_tdata, hdr_q[0]);
        chk("ack_tready", s_ack_tready, 1);
        chk("ack_err", ack_err_o, err_m);
        if (!e_alloc_v) saw_full = 1'b1;
        if (e_hdr_v && !m_hdr_tready && s_wrdone_tvalid && alloc_q.size() != 0) saw_bp = 1'b1;

        // Model advance, all decisions taken from the pre-edge state
        a_hs = e_alloc_v && m_alloc_tready;
        w_hs = s_wrdone_tvalid && e_wr_r;
        h_hs = e_hdr_v && m_hdr_tready;
`ifdef EVBUF_ACK_CHECK_EN
        ack_good = (done_q.size() != 0) && (s_ack_tdata == 12'(done_q[0]));
`else
        ack_good = done_q.size() != 0;
`endif
        if (s_ack_tvalid) begin
            if (ack_good) void'(done_q.pop_front());
            else err_m = 1'b1;
        end
        if (h_hs) void'(hdr_q.pop_front());
        if (w_hs) begin
            w_addr = alloc_q.pop_front();
            done_q.push_back(w_addr);
            hdr_q.push_back({3'b000, w_addr, s_wrdone_tdata});
        end
        if (a_hs) begin
            alloc_q.push_back(a_addr);
            alloc_cnt++;
        end
    endtask

    initial begin
        do_reset();
        // Fill the ring: lots of allocation, few acks
        repeat (400) run_cycle(90, 60, 80, 5, 0);
        // Header backpressure with steady acks
        repeat (400) run_cycle(80, 80, 10, 40, 5);
        // Reset in the middle of traffic
        do_reset();
        repeat (400) run_cycle(70, 70, 70, 70, 20);
        // Drain: acks outpace completions, some with nothing completed
        repeat (300) run_cycle(20, 50, 90, 90, 10);
        do_reset();
        repeat (300) run_cycle(95, 95, 95, 60, 0);
        chk("saw_full", saw_full, 1);
        chk("saw_backpressure", saw_bp, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
